// File: rtl/dict_value_pkg.sv
// Shared constants and FSM state type for the dictionary-value stream scheduler.
package dict_value_pkg;

  localparam int unsigned DEFAULT_CHUNK_SIZE    = 4;
  localparam int unsigned DEFAULT_CODEBOOK_SIZE = 8;
  localparam int unsigned DEFAULT_NUM_CHUNKS    = 32;
  localparam int unsigned DEFAULT_INDEX_BITS    = $clog2(DEFAULT_CODEBOOK_SIZE);
  localparam int unsigned DEFAULT_STREAM_LEN    = DEFAULT_NUM_CHUNKS * DEFAULT_CHUNK_SIZE;
  localparam int unsigned DEFAULT_OUT_BITS      = DEFAULT_NUM_CHUNKS * DEFAULT_INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    WAIT_DONE = 2'd2,
    RESULT    = 2'd3
  } sched_state_t;

endpackage

// File: rtl/dict_value_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module dict_value_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_BITS-1:0] ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_BITS-1:0] grant_id,
  output logic               any
);

  // Index reached by stepping off positions above base, modulo NUM_REQ.
  function automatic logic [ID_BITS-1:0] wrap_idx(input int unsigned base, input int unsigned off);
    int unsigned s;
    s = base + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_BITS'(s);
  endfunction

  logic [ID_BITS-1:0] idx;

  // Scan from ptr upward; the first asserted request wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = wrap_idx(32'(ptr), off);
      if (!any && req[idx]) begin
        any         = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/dict_value_stream_scheduler.sv
// Round-robin scheduler feeding one serial dictionary-value compressor from NUM_REQ block sources.
module dict_value_stream_scheduler
  import dict_value_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned CHUNK_SIZE    = DEFAULT_CHUNK_SIZE,
  parameter int unsigned CODEBOOK_SIZE = DEFAULT_CODEBOOK_SIZE,
  parameter int unsigned NUM_CHUNKS    = DEFAULT_NUM_CHUNKS,
  parameter int unsigned TIMEOUT       = 16,
  localparam int unsigned INDEX_BITS   = $clog2(CODEBOOK_SIZE),
  localparam int unsigned STREAM_LEN   = NUM_CHUNKS * CHUNK_SIZE,
  localparam int unsigned OUT_BITS     = NUM_CHUNKS * INDEX_BITS,
  localparam int unsigned ID_BITS      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*STREAM_LEN-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          cmp_data_in,
  output logic                          cmp_data_valid,
  input  logic [OUT_BITS-1:0]           cmp_compressed_output,
  input  logic                          cmp_done,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [OUT_BITS-1:0]           res_data,
  output logic [ID_BITS-1:0]            res_id,
  output logic                          res_error,
  output logic                          busy
);

  localparam int unsigned CNT_BITS = $clog2(STREAM_LEN);
  localparam int unsigned TO_BITS  = $clog2(TIMEOUT + 1);

  sched_state_t          state_q, state_d;
  logic [STREAM_LEN-1:0] shift_q, shift_d;
  logic [CNT_BITS-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TO_BITS-1:0]    to_cnt_q, to_cnt_d;
  logic [ID_BITS-1:0]    grant_id_q, grant_id_d;
  logic [ID_BITS-1:0]    rr_ptr_q, rr_ptr_d;
  logic [OUT_BITS-1:0]   res_data_d;
  logic [ID_BITS-1:0]    res_id_d;
  logic                  res_error_d;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [ID_BITS-1:0]    arb_grant_id;
  logic                  arb_any;

  logic [STREAM_LEN-1:0] req_block [NUM_REQ];

  // Split the flat request bus into one block per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_block[gi] = req_data[gi*STREAM_LEN +: STREAM_LEN];
  end

  dict_value_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_BITS (ID_BITS)
  ) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr_q),
    .grant    (arb_grant),
    .grant_id (arb_grant_id),
    .any      (arb_any)
  );

  // Handshake and stream outputs decode straight from the state register.
  assign req_ready      = (state_q == IDLE) ? arb_grant : '0;
  assign cmp_data_valid = (state_q == SHIFT);
  assign cmp_data_in    = (state_q == SHIFT) & shift_q[STREAM_LEN-1];
  assign res_valid      = (state_q == RESULT);
  assign busy           = (state_q != IDLE);

  // Next-state and datapath update for the grant/shift/wait/result sequence.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    res_data_d  = res_data;
    res_id_d    = res_id;
    res_error_d = res_error;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          shift_d    = req_block[arb_grant_id];
          grant_id_d = arb_grant_id;
          bit_cnt_d  = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        shift_d   = {shift_q[STREAM_LEN-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + CNT_BITS'(1);
        if (bit_cnt_q == CNT_BITS'(STREAM_LEN - 1)) begin
          to_cnt_d = '0;
          state_d  = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        to_cnt_d = to_cnt_q + TO_BITS'(1);
        if (cmp_done) begin
          res_data_d  = cmp_compressed_output;
          res_error_d = 1'b0;
          res_id_d    = grant_id_q;
          state_d     = RESULT;
        end else if (to_cnt_q == TO_BITS'(TIMEOUT - 1)) begin
          res_data_d  = '0;
          res_error_d = 1'b1;
          res_id_d    = grant_id_q;
          state_d     = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          rr_ptr_d = (grant_id_q == ID_BITS'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_BITS'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight block or result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      to_cnt_q   <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      res_data   <= '0;
      res_id     <= '0;
      res_error  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      to_cnt_q   <= to_cnt_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      res_data   <= res_data_d;
      res_id     <= res_id_d;
      res_error  <= res_error_d;
    end
  end

endmodule

// File: tb/tb_dict_value_stream_scheduler.sv
// Directed bench for the round-robin compressor scheduler with an inline compressor stand-in.
module tb_dict_value_stream_scheduler;

  localparam int unsigned NR = 4;
  localparam int unsigned SL = 128;
  localparam int unsigned OB = 96;
  localparam int unsigned TO = 16;
  localparam logic [OB-1:0] GARBAGE = 96'hBADBADBADBADBADBADBADBAD;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*SL-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            cmp_data_in;
  logic            cmp_data_valid;
  logic [OB-1:0]   cmp_compressed_output;
  logic            cmp_done;
  logic            res_valid;
  logic            res_ready;
  logic [OB-1:0]   res_data;
  logic [1:0]      res_id;
  logic            res_error;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [SL-1:0] dblk [NR];
  logic [SL-1:0] d_single;
  logic [SL-1:0] d_x;

  dict_value_stream_scheduler dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .req_valid             (req_valid),
    .req_data              (req_data),
    .req_ready             (req_ready),
    .cmp_data_in           (cmp_data_in),
    .cmp_data_valid        (cmp_data_valid),
    .cmp_compressed_output (cmp_compressed_output),
    .cmp_done              (cmp_done),
    .res_valid             (res_valid),
    .res_ready             (res_ready),
    .res_data              (res_data),
    .res_id                (res_id),
    .res_error             (res_error),
    .busy                  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compressor stand-in: index k is the low 3 bits of chunk k xor k.
  function automatic logic [OB-1:0] model_out(input logic [SL-1:0] d);
    logic [OB-1:0] o;
    o = '0;
    for (int k = 0; k < 32; k++) o[k*3 +: 3] = d[k*4 +: 3] ^ 3'(k);
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // One full block: grant, 128-bit stream, done or timeout, optional hold, release.
  task automatic run_block(input string tag, input int exp_id, input logic [SL-1:0] data,
                           input bit give_done, input int spur_lo, input int spur_hi,
                           input int hold);
    logic [SL-1:0] bits;
    logic [OB-1:0] exp_data;
    logic          exp_err;
    int nvalid;
    int nready;
    int nhold;
    #1;
    check({tag, " grant"}, 128'(req_ready), 128'(NR'(1) << exp_id));
    check({tag, " idle_busy"}, 128'(busy), 128'(0));
    tick;
    bits = '0;
    nvalid = 0;
    nready = 0;
    for (int i = 0; i < int'(SL); i++) begin
      cmp_done = (i >= spur_lo) && (i < spur_hi);
      cmp_compressed_output = GARBAGE;
      #1;
      if (cmp_data_valid === 1'b1) nvalid++;
      if (req_ready !== '0) nready++;
      bits = {bits[SL-2:0], cmp_data_in};
      tick;
    end
    cmp_done = 1'b0;
    #1;
    check({tag, " stream"}, bits, data);
    check({tag, " valid_cycles"}, 128'(nvalid), 128'(SL));
    check({tag, " ready_in_shift"}, 128'(nready), 128'(0));
    check({tag, " valid_after"}, 128'(cmp_data_valid), 128'(0));
    check({tag, " res_early"}, 128'(res_valid), 128'(0));
    if (give_done) begin
      cmp_done = 1'b1;
      cmp_compressed_output = model_out(data);
      tick;
      cmp_done = 1'b0;
      cmp_compressed_output = GARBAGE;
      #1;
      exp_data = model_out(data);
      exp_err  = 1'b0;
    end else begin
      repeat (TO - 1) tick;
      #1;
      check({tag, " pre_timeout"}, 128'(res_valid), 128'(0));
      tick;
      #1;
      exp_data = '0;
      exp_err  = 1'b1;
    end
    check({tag, " res_valid"}, 128'(res_valid), 128'(1));
    check({tag, " res_id"}, 128'(res_id), 128'(exp_id));
    check({tag, " res_data"}, 128'(res_data), 128'(exp_data));
    check({tag, " res_error"}, 128'(res_error), 128'(exp_err));
    nhold = 0;
    for (int h = 0; h < hold; h++) begin
      tick;
      #1;
      if (res_valid !== 1'b1 || res_data !== exp_data || res_id !== 2'(exp_id) ||
          res_error !== exp_err || req_ready !== '0 || busy !== 1'b1) nhold++;
    end
    if (hold > 0) check({tag, " hold_stable"}, 128'(nhold), 128'(0));
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    #1;
    check({tag, " released"}, 128'(res_valid), 128'(0));
    check({tag, " idle_after"}, 128'(busy), 128'(0));
  endtask

  initial begin
    d_single = 128'h0123456789ABCDEF0123456789ABCDEF;
    dblk[0]  = 128'hA5A50F0F3C3C9669F00DBEEF12345678;
    dblk[1]  = 128'h80000000000000000000000000000001;
    dblk[2]  = 128'hFFFFFFFF00000000FFFFFFFF00000000;
    dblk[3]  = 128'h5555AAAA5555AAAAC3C33C3C7E7E8181;
    d_x      = 128'hDEADBEEFCAFEF00D0BADF00D13579BDF;
    rst_n = 1'b1;
    req_valid = '0;
    req_data = '0;
    res_ready = 1'b0;
    cmp_done = 1'b0;
    cmp_compressed_output = '0;
    #2 rst_n = 1'b0;
    tick;
    tick;
    #1;
    check("rst busy", 128'(busy), 128'(0));
    check("rst res_valid", 128'(res_valid), 128'(0));
    check("rst cmp_valid", 128'(cmp_data_valid), 128'(0));
    check("rst cmp_in", 128'(cmp_data_in), 128'(0));
    check("rst req_ready", 128'(req_ready), 128'(0));
    check("rst res_data", 128'(res_data), 128'(0));
    check("rst res_id", 128'(res_id), 128'(0));
    check("rst res_error", 128'(res_error), 128'(0));
    rst_n = 1'b1;
    tick;

    // Single requester 2.
    req_data[2*SL +: SL] = d_single;
    req_valid = 4'b0100;
    run_block("single", 2, d_single, 1'b1, 0, 0, 0);
    req_valid = '0;
    #1;
    check("single no_regrant", 128'(req_ready), 128'(0));

    // Fresh reset so the pointer restarts at 0.
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;

    // All four continuously: 0,1,2,3,0 then backpressure, then timeout on 1.
    for (int i = 0; i < int'(NR); i++) req_data[i*SL +: SL] = dblk[i];
    req_valid = 4'b1111;
    run_block("rr0", 0, dblk[0], 1'b1, 0, 0, 0);
    run_block("rr1", 1, dblk[1], 1'b1, 0, 0, 0);
    run_block("rr2", 2, dblk[2], 1'b1, 0, 0, 0);
    run_block("rr3", 3, dblk[3], 1'b1, 0, 0, 0);
    run_block("rr0_bp", 0, dblk[0], 1'b1, 0, 0, 20);
    run_block("timeout", 1, dblk[1], 1'b0, 0, 0, 0);

    // Pointer advanced past the error result; reset partway through the stream.
    #1;
    check("post_timeout grant", 128'(req_ready), 128'(4'b0100));
    tick;
    repeat (60) tick;
    #1;
    check("mid_shift valid", 128'(cmp_data_valid), 128'(1));
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check("rst_mid cmp_valid", 128'(cmp_data_valid), 128'(0));
    check("rst_mid res_valid", 128'(res_valid), 128'(0));
    check("rst_mid busy", 128'(busy), 128'(0));
    check("rst_mid res_error", 128'(res_error), 128'(0));
    check("rst_mid req_ready", 128'(req_ready), 128'(0));
    tick;
    req_data[1*SL +: SL] = d_x;
    req_valid = 4'b0110;
    rst_n = 1'b1;
    run_block("after_rst", 1, d_x, 1'b1, 10, 20, 0);
    req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
